// File: rtl/capture_box_decimator.sv
`default_nettype none
// ============================================================================
// Module   : capture_box_decimator
// Purpose  : Box-filter and decimate a raster RGB444 pixel stream by F=2 or
//            F=4 in both directions, producing frame-buffer writes.
//            Each FxF block is averaged (truncating) instead of dropping
//            pixels, so the reduced-resolution images do not alias.
// Ports    : pclk         - pixel clock (only clock)
//            rst          - synchronous active-high reset
//            rez_160x120  - F=4 when set at frame_start (has priority)
//            rez_320x240  - F=2 when set at frame_start (also default)
//            frame_start  - one-cycle start-of-frame pulse
//            in_valid     - qualifies in_data, one pixel per cycle
//            in_data      - pixel {R[11:8],G[7:4],B[3:0]}
//            out_we       - frame-buffer write enable (one cycle per block)
//            out_addr     - frame-buffer write address
//            out_data     - averaged pixel {R,G,B}
//            frame_done   - one-cycle pulse after the last write of a frame
// Revision : 1.0 - initial release
// ============================================================================
module capture_box_decimator #(
    parameter int H_IN = 640,
    parameter int V_IN = 480
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        rez_160x120,
    input  logic        rez_320x240,
    input  logic        frame_start,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    output logic        out_we,
    output logic [16:0] out_addr,
    output logic [11:0] out_data,
    output logic        frame_done
);

    localparam int C_X_W      = $clog2(H_IN);
    localparam int C_Y_W      = $clog2(V_IN);
    localparam int C_LB_DEPTH = H_IN / 2;
    localparam int C_LB_W     = $clog2(C_LB_DEPTH);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_ACTIVE = 2'd1;
    localparam logic [1:0] C_ST_DONE   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_f4;          // 1: F=4, 0: F=2 (latched at frame_start)
    logic [C_X_W-1:0]  r_x;
    logic [C_Y_W-1:0]  r_y;
    logic [23:0]       r_hacc;        // three 8-bit channel sums, {R,G,B}
    logic              r_last;        // last pixel of frame accepted last cycle
    logic              r_we;
    logic [16:0]       r_addr;
    logic [11:0]       r_data;
    logic              r_done;

    // Line buffer: one packed {R,G,B} 8-bit-per-channel partial sum per column.
    logic [23:0]       r_lb [0:C_LB_DEPTH-1];

    logic              w_accept;
    logic              w_x_first, w_x_last, w_y_first, w_y_last;
    logic              w_last_pix;
    logic [C_LB_W-1:0] w_col;
    logic [23:0]       w_lb_rd;
    logic [23:0]       w_hsum;
    logic [23:0]       w_total;
    logic [11:0]       w_avg;
    logic [16:0]       w_row, w_row_len, w_addr;

    assign w_accept   = (r_state == C_ST_ACTIVE) && in_valid && !frame_start;
    assign w_x_first  = r_f4 ? (r_x[1:0] == 2'd0) : ~r_x[0];
    assign w_x_last   = r_f4 ? (r_x[1:0] == 2'd3) :  r_x[0];
    assign w_y_first  = r_f4 ? (r_y[1:0] == 2'd0) : ~r_y[0];
    assign w_y_last   = r_f4 ? (r_y[1:0] == 2'd3) :  r_y[0];
    assign w_last_pix = (r_x == C_X_W'(H_IN - 1)) && (r_y == C_Y_W'(V_IN - 1));

    assign w_col   = r_f4 ? C_LB_W'(r_x >> 2) : C_LB_W'(r_x >> 1);
    assign w_lb_rd = r_lb[w_col];

    // Per-channel sums. The horizontal sum restarts on the first pixel of a
    // block; the vertical total adds the partial sum held for this column.
    // Averages are bit slices: >>4 for F=4, >>2 for F=2 (totals fit 8 bits).
    always_comb begin
        w_hsum  = '0;
        w_total = '0;
        w_avg   = '0;
        for (int c = 0; c < 3; c++) begin
            w_hsum[c*8 +: 8]  = (w_x_first ? 8'd0 : r_hacc[c*8 +: 8])
                              + {4'd0, in_data[c*4 +: 4]};
            w_total[c*8 +: 8] = w_lb_rd[c*8 +: 8] + w_hsum[c*8 +: 8];
            w_avg[c*4 +: 4]   = r_f4 ? w_total[c*8+4 +: 4] : w_total[c*8+2 +: 4];
        end
    end

    assign w_row     = r_f4 ? 17'(r_y >> 2) : 17'(r_y >> 1);
    assign w_row_len = r_f4 ? 17'(H_IN / 4) : 17'(H_IN / 2);
    assign w_addr    = (w_row * w_row_len) + 17'(w_col);

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (frame_start) begin
            w_next_state = C_ST_ACTIVE;
        end else if (w_accept && w_last_pix) begin
            w_next_state = C_ST_DONE;
        end
    end

    // ------------------------------------------------------------------
    // Counters, horizontal accumulator and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_f4   <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_hacc <= '0;
            r_last <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_done <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= r_last;
            r_last <= 1'b0;
            if (frame_start) begin
                r_f4   <= rez_160x120;
                r_x    <= '0;
                r_y    <= '0;
                r_hacc <= '0;
            end else if (w_accept) begin
                r_hacc <= w_hsum;
                if (r_x == C_X_W'(H_IN - 1)) begin
                    r_x <= '0;
                    r_y <= w_last_pix ? '0 : r_y + C_Y_W'(1);
                end else begin
                    r_x <= r_x + C_X_W'(1);
                end
                if (w_x_last && w_y_last) begin
                    r_we   <= 1'b1;
                    r_addr <= w_addr;
                    r_data <= w_avg;
                end
                r_last <= w_last_pix;
            end
        end
    end

    // Line buffer has no reset: the first line of every block row overwrites.
    always_ff @(posedge pclk) begin
        if (w_accept && w_x_last) begin
            r_lb[w_col] <= w_y_first ? w_hsum : w_total;
        end
    end

    assign out_we     = r_we;
    assign out_addr   = r_addr;
    assign out_data   = r_data;
    assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_capture_box_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_box_decimator
// Purpose  : Self-checking bench for capture_box_decimator on a reduced
//            32x24 raster. Pixels are remembered per frame and every block
//            average, address and write timing is recomputed from the image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_box_decimator;

    localparam int H = 32;
    localparam int V = 24;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        rez_160x120 = 1'b0;
    logic        rez_320x240 = 1'b0;
    logic        frame_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = 12'd0;
    logic        out_we;
    logic [16:0] out_addr;
    logic [11:0] out_data;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [11:0] img [V][H];
    int          acc [V][H];
    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];
    int done_cyc[$];

    capture_box_decimator #(.H_IN(H), .V_IN(V)) dut (
        .pclk       (pclk),
        .rst        (rst),
        .rez_160x120(rez_160x120),
        .rez_320x240(rez_320x240),
        .frame_start(frame_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_we     (out_we),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (out_we === 1'b1) begin
            obs_addr.push_back(int'(out_addr));
            obs_data.push_back(int'(out_data));
            obs_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) done_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cyc.delete();
    endtask

    function automatic logic [11:0] gen_pix(input int pattern, input int x, input int y);
        if (pattern == 1) return 12'hA5C;
        if (pattern == 2 && x < 4 && y < 4) return {4'(4 * y + x), 4'hF, 4'h0};
        return 12'($urandom);
    endfunction

    // Drive one frame (or its first 'rows' lines) with random gaps, then
    // compare every write against block averages of the stored image.
    task automatic run_frame(input bit s160, input bit s320, input int pattern,
                             input int rows, input int chg_row,
                             input bit c160, input bit c320);
        int f;
        int n;
        int nexp;
        f = s160 ? 4 : 2;
        clear_obs();
        rez_160x120 = s160;
        rez_320x240 = s320;
        frame_start = 1'b1;
        in_valid    = 1'($urandom);   // a pixel here must be dropped
        in_data     = 12'($urandom);
        step();
        frame_start = 1'b0;
        n = 0;
        while (n < rows * H) begin
            int x;
            int y;
            y = n / H;
            x = n % H;
            if (y == chg_row && x == 0) begin
                rez_160x120 = c160;
                rez_320x240 = c320;
            end
            if ($urandom_range(0, 3) != 0) begin
                img[y][x] = gen_pix(pattern, x, y);
                in_valid  = 1'b1;
                in_data   = img[y][x];
                step();
                acc[y][x] = cyc;
                n++;
            end else begin
                in_valid = 1'b0;
                in_data  = 12'($urandom);
                step();
            end
        end
        in_valid = 1'b0;
        repeat (4) step();

        nexp = (rows / f) * (H / f);
        check("write_count", obs_addr.size(), nexp);
        for (int i = 0; i < nexp && i < obs_addr.size(); i++) begin
            int bx;
            int by;
            int sr;
            int sg;
            int sb;
            logic [11:0] p;
            logic [11:0] expd;
            bx = i % (H / f);
            by = i / (H / f);
            sr = 0; sg = 0; sb = 0;
            for (int yy = 0; yy < f; yy++)
                for (int xx = 0; xx < f; xx++) begin
                    p  = img[by*f+yy][bx*f+xx];
                    sr += int'(p[11:8]);
                    sg += int'(p[7:4]);
                    sb += int'(p[3:0]);
                end
            expd = {4'(sr / (f*f)), 4'(sg / (f*f)), 4'(sb / (f*f))};
            check("wr_addr", obs_addr[i], by * (H / f) + bx);
            check("wr_data", obs_data[i], expd);
            check("wr_latency", obs_cyc[i], acc[by*f+f-1][bx*f+f-1]);
        end
        if (rows == V) begin
            check("done_count", done_cyc.size(), 1);
            if (done_cyc.size() > 0) check("done_cycle", done_cyc[0], acc[V-1][H-1] + 1);
        end else begin
            check("done_count_abort", done_cyc.size(), 0);
        end
    endtask

    initial begin
        int bad;
        // Reset state
        repeat (3) step();
        check("rst_we", out_we, 0);
        check("rst_addr", out_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_done", frame_done, 0);
        rst = 1'b0;

        // in_valid without frame_start is ignored
        clear_obs();
        repeat (100) begin
            in_valid = 1'b1;
            in_data  = 12'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("idle_writes", obs_addr.size(), 0);
        check("idle_done", done_cyc.size(), 0);
        check("idle_addr", out_addr, 0);
        check("idle_data", out_data, 0);

        // F=2 constant image
        run_frame(1'b0, 1'b0, 1, V, -1, 1'b0, 1'b0);
        if (obs_addr.size() > 0) check("a_last_addr", obs_addr[obs_addr.size()-1], (H/2)*(V/2) - 1);
        bad = 0;
        foreach (obs_data[i]) if (obs_data[i] != 12'hA5C) bad++;
        check("a_all_a5c", bad, 0);

        // in_valid ignored in DONE
        clear_obs();
        repeat (20) begin
            in_valid = 1'b1;
            in_data  = 12'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("done_ignore_wr", obs_addr.size(), 0);
        check("done_ignore_done", done_cyc.size(), 0);

        // F=4 with the ramp block at the origin
        run_frame(1'b1, 1'b0, 2, V, -1, 1'b1, 1'b0);
        if (obs_addr.size() > 0) begin
            check("b_first_data", obs_data[0], 12'h7F0);
            check("b_first_addr", obs_addr[0], 0);
        end

        // Both rez high -> F=4
        run_frame(1'b1, 1'b1, 0, V, -1, 1'b1, 1'b1);
        if (obs_addr.size() > 0) check("c_last_addr", obs_addr[obs_addr.size()-1], (H/4)*(V/4) - 1);

        // Mid-frame rez changes only take effect at the next frame_start
        run_frame(1'b0, 1'b0, 0, V, V/2, 1'b0, 1'b1);
        run_frame(1'b0, 1'b1, 0, V, -1, 1'b0, 1'b1);
        run_frame(1'b0, 1'b0, 0, V, V/2, 1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 0, V, V/2, 1'b0, 1'b0);

        // Abort by frame_start, then by reset
        run_frame(1'b0, 1'b0, 0, V/2, -1, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 0, 6, -1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check("mid_rst_we", out_we, 0);
        check("mid_rst_addr", out_addr, 0);
        check("mid_rst_data", out_data, 0);
        rst = 1'b0;
        clear_obs();
        repeat (50) begin
            in_valid = 1'b1;
            in_data  = 12'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check("post_rst_writes", obs_addr.size(), 0);
        check("post_rst_done", done_cyc.size(), 0);

        // Clean frame after reset
        run_frame(1'b0, 1'b0, 0, V, -1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/capture_box_decimator.md
# capture_box_decimator

Pixel-clock-domain stage between the camera capture stage and the write port of the dual-port frame buffer. Consumes the full-resolution 640x480 RGB444 pixel stream. Produces a box-filtered, decimated write stream (address, data, write enable) for the 320x240 or 160x120 frame-buffer layout. Averaging each FxF block replaces plain pixel dropping, which removes aliasing in the reduced-resolution modes.

## Interface

Parameters:
- H_IN, 640, input pixels per line
- V_IN, 480, input lines per frame

Ports:
- pclk  in  1  camera pixel clock; sole clock
- rst  in  1  synchronous, active-high reset
- rez_160x120  in  1  selects F=4 (wins over rez_320x240)
- rez_320x240  in  1  selects F=2; both low also selects F=2
- frame_start  in  1  one-cycle pulse at start of frame (derived from camera vsync)
- in_valid  in  1  qualifies in_data; one pixel per asserted cycle, raster order
- in_data  in  12  pixel {R[11:8],G[7:4],B[3:0]}
- out_we  out  1  frame-buffer write enable
- out_addr  out  17  frame-buffer write address
- out_data  out  12  averaged pixel {R,G,B}
- frame_done  out  1  one-cycle pulse after last output of a complete frame

## Operation

- State machine: IDLE, ACTIVE, DONE.
  - Reset puts the block in IDLE.
  - frame_start in any state: go to ACTIVE, x=y=0, latch F from the rez inputs.
  - ACTIVE, pixel (H_IN-1, V_IN-1) accepted: go to DONE.
  - DONE waits for frame_start. in_valid is ignored in IDLE and DONE.
- Rez inputs are sampled only on frame_start. Changes mid-frame have no effect until the next frame_start.
- Counters: x advances on each accepted pixel and wraps H_IN-1 -> 0. y increments on that wrap. No href resync; line length is fixed at H_IN.
- Horizontal accumulator: three per-channel sums of F consecutive pixels. It restarts when x%F==0.
- Line buffer: H_IN/2 entries x 3 channels x 8 bits, indexed by x/F. Only H_IN/F entries are used.
  - At x%F==F-1, the entry receives the horizontal sum.
  - The sum is written when y%F==0 and added to the entry otherwise.
- Emit condition: x%F==F-1 and y%F==F-1. The output is the full block sum plus the current horizontal sum, shifted right by 2*log2(F), truncating, per channel.
- out_addr = (y/F)*(H_IN/F) + x/F. Ranges: 0..76799 for F=2, 0..19199 for F=4.
- Channel sums are at most 16*15=240 and fit in 8 bits. No saturation is needed.

## Timing

- Reset values: out_we=0, out_addr=0, out_data=0, frame_done=0. Counters, accumulator and state are cleared. Line buffer contents are don't-care; the first line of each block row overwrites them.
- Latency: out_we/out_addr/out_data are registered and valid exactly 1 cycle after the in_valid cycle of the block's last pixel. out_we is high for that single cycle.
- Output rate is at most 1 per F input pixels. No back-pressure; the frame buffer always accepts.
- frame_done is high 1 cycle after the final out_we of the frame, i.e. 2 cycles after the last in_valid.
- frame_start and in_valid in the same cycle: frame_start wins and that pixel is dropped.
- frame_start mid-frame aborts the frame: no frame_done, and addressing restarts at 0. A pending out_we already registered still completes.
- Gaps in in_valid are allowed anywhere. State holds during gaps.
- rst mid-frame: outputs go to reset values the next cycle. No further writes occur until frame_start.

## Test plan

- Reset, then 100 cycles of in_valid with no frame_start -> out_we never asserts and all outputs stay 0. frame_done stays 0.
- Both rez low, frame_start, 307200 pixels of 0xA5C with random in_valid gaps -> exactly 76800 writes. Addresses run 0..76799 in order, all data 0xA5C, one frame_done 2 cycles after the last in_valid.
- rez_160x120=1, first 4x4 block with R = 4*row+col (0..15), G=15, B=0 -> write at addr 0 with data 0x7F0 (120>>4=7), asserted 1 cycle after pixel (3,3).
- Both rez inputs high -> F=4: 19200 writes, last address 19199.
- rez_320x240 raised at y=100 of an F=2 frame -> rest of that frame still F=2. After the next frame_start, F=2 is confirmed. Raising rez_160x120 mid-frame likewise takes effect only at the next frame_start.
- frame_start at y=200, then rst pulse at y=50 of the new frame -> no frame_done for the aborted frame. After the restart, the first write is addr 0. After rst, outputs are 0 and no writes occur until the next frame_start.
